// File: rtl/mcu_bus_arbiter.sv
// mcu_bus_arbiter: shares one memory port between an MCU that can never be
// stalled and an internal requester that only gets idle cycles. Read data is
// steered back to its issuer through an owner-tag pipeline matching the
// memory read latency, and long device waits raise a sticky starvation flag.
module mcu_bus_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_LIM = 64
) (
    input  logic          clk,
    input  logic          nsclr,
    input  logic [AW-1:0] mcu_addr,
    input  logic          mcu_write,
    input  logic          mcu_read,
    input  logic [DW-1:0] mcu_wrdata,
    output logic [DW-1:0] mcu_rddata,
    output logic          mcu_rdvalid,
    input  logic          dev_req,
    input  logic          dev_we,
    input  logic [AW-1:0] dev_addr,
    input  logic [DW-1:0] dev_wrdata,
    output logic          dev_gnt,
    output logic [DW-1:0] dev_rddata,
    output logic          dev_rdvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic [DW-1:0] mem_wrdata,
    input  logic [DW-1:0] mem_rddata,
    output logic          starve,
    input  logic          clr_starve,
    output logic          mcu_err
);

    typedef enum logic {IDLE, DEV_WAIT} state_t;

    localparam logic [7:0] LIM = 8'(STARVE_LIM);

    state_t          state, state_nxt;
    logic            mcu_busy;
    logic            mcu_acc;
    logic            mcu_rd;
    logic            dev_rd;
    logic            rd_issue;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdat_q;
    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] own_pipe;   // 1 = device, 0 = MCU
    logic            rd_ret;
    logic [DW-1:0]   mcu_rd_q;
    logic [DW-1:0]   dev_rd_q;
    logic [7:0]      wait_cnt;
    logic            cnt_inc;
    logic            starve_set;

    // Access arbitration: MCU wins outright, device only on MCU-idle cycles.
    // A simultaneous MCU read+write is treated as a write; the read is dropped.
    always_comb begin
        mcu_busy   = mcu_write || mcu_read;
        mcu_acc    = nsclr && mcu_busy;
        mcu_rd     = nsclr && mcu_read && !mcu_write;
        dev_gnt    = nsclr && dev_req && !mcu_busy;
        dev_rd     = dev_gnt && !dev_we;
        rd_issue   = mcu_rd || dev_rd;
        mem_we     = (nsclr && mcu_write) || (dev_gnt && dev_we);
        mem_re     = rd_issue;
        mem_addr   = addr_q;
        mem_wrdata = wdat_q;
        if (mcu_acc) begin
            mem_addr   = mcu_addr;
            mem_wrdata = mcu_wrdata;
        end else if (dev_gnt) begin
            mem_addr   = dev_addr;
            mem_wrdata = dev_wrdata;
        end
    end

    // Hold the last driven address/data so the port stays quiet when idle.
    always_ff @(posedge clk) begin
        if (!nsclr) begin
            addr_q <= '0;
            wdat_q <= '0;
        end else if (mcu_acc || dev_gnt) begin
            addr_q <= mem_addr;
            wdat_q <= mem_wrdata;
        end
    end

    // Owner-tag pipeline: one {valid, owner} entry per issued read, aligned
    // so the last stage lines up with the cycle its data arrives.
    always_ff @(posedge clk) begin
        if (!nsclr) begin
            vld_pipe <= '0;
            own_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_issue;
            own_pipe[0] <= dev_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                own_pipe[i] <= own_pipe[i-1];
            end
        end
    end

    // Steer returning data to its owner; outputs show the held copy otherwise.
    always_comb begin
        rd_ret      = nsclr && vld_pipe[RD_LAT-1];
        mcu_rdvalid = rd_ret && !own_pipe[RD_LAT-1];
        dev_rdvalid = rd_ret && own_pipe[RD_LAT-1];
        mcu_rddata  = mcu_rdvalid ? mem_rddata : mcu_rd_q;
        dev_rddata  = dev_rdvalid ? mem_rddata : dev_rd_q;
    end

    // Capture returned data so it persists between valid pulses.
    always_ff @(posedge clk) begin
        if (!nsclr) begin
            mcu_rd_q <= '0;
            dev_rd_q <= '0;
        end else begin
            if (mcu_rdvalid) mcu_rd_q <= mem_rddata;
            if (dev_rdvalid) dev_rd_q <= mem_rddata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!nsclr) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: DEV_WAIT for every cycle the device is held off by the MCU.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (dev_req && mcu_busy) state_nxt = DEV_WAIT;
            DEV_WAIT: if (!dev_req || dev_gnt) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        cnt_inc    = nsclr && (state_nxt == DEV_WAIT);
        starve_set = cnt_inc && (wait_cnt != 8'hFF) && (wait_cnt + 8'd1 == LIM);
    end

    // Saturating count of consecutive blocked cycles.
    always_ff @(posedge clk) begin
        if (!nsclr || clr_starve || !cnt_inc) wait_cnt <= '0;
        else if (wait_cnt != 8'hFF)           wait_cnt <= wait_cnt + 8'd1;
    end

    // Sticky flags; a set in the same cycle as a clear takes precedence.
    always_ff @(posedge clk) begin
        if (!nsclr) begin
            starve  <= 1'b0;
            mcu_err <= 1'b0;
        end else begin
            if (starve_set)      starve <= 1'b1;
            else if (clr_starve) starve <= 1'b0;
            if (mcu_write && mcu_read) mcu_err <= 1'b1;
            else if (clr_starve)       mcu_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mcu_bus_arbiter.sv
// Directed bench for mcu_bus_arbiter. Three instances share the stimulus:
// index 0 has RD_LAT=1, index 1 RD_LAT=2, index 2 RD_LAT=3 (STARVE_LIM=64).
module tb_mcu_bus_arbiter;

    logic        clk = 1'b0;
    logic        nsclr;
    logic [15:0] mcu_addr, mcu_wrdata, dev_addr, dev_wrdata, mem_rddata;
    logic        mcu_write, mcu_read, dev_req, dev_we, clr_starve;

    logic [15:0] o_mcu_rddata [3];
    logic        o_mcu_rdvalid [3];
    logic        o_dev_gnt [3];
    logic [15:0] o_dev_rddata [3];
    logic        o_dev_rdvalid [3];
    logic [15:0] o_mem_addr [3];
    logic        o_mem_we [3];
    logic        o_mem_re [3];
    logic [15:0] o_mem_wrdata [3];
    logic        o_starve [3];
    logic        o_mcu_err [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mcu_bus_arbiter #(.AW(16), .DW(16), .RD_LAT(1), .STARVE_LIM(64)) u1 (
        .clk(clk), .nsclr(nsclr), .mcu_addr(mcu_addr), .mcu_write(mcu_write),
        .mcu_read(mcu_read), .mcu_wrdata(mcu_wrdata), .mcu_rddata(o_mcu_rddata[0]),
        .mcu_rdvalid(o_mcu_rdvalid[0]), .dev_req(dev_req), .dev_we(dev_we),
        .dev_addr(dev_addr), .dev_wrdata(dev_wrdata), .dev_gnt(o_dev_gnt[0]),
        .dev_rddata(o_dev_rddata[0]), .dev_rdvalid(o_dev_rdvalid[0]),
        .mem_addr(o_mem_addr[0]), .mem_we(o_mem_we[0]), .mem_re(o_mem_re[0]),
        .mem_wrdata(o_mem_wrdata[0]), .mem_rddata(mem_rddata), .starve(o_starve[0]),
        .clr_starve(clr_starve), .mcu_err(o_mcu_err[0]));

    mcu_bus_arbiter #(.AW(16), .DW(16), .RD_LAT(2), .STARVE_LIM(64)) u2 (
        .clk(clk), .nsclr(nsclr), .mcu_addr(mcu_addr), .mcu_write(mcu_write),
        .mcu_read(mcu_read), .mcu_wrdata(mcu_wrdata), .mcu_rddata(o_mcu_rddata[1]),
        .mcu_rdvalid(o_mcu_rdvalid[1]), .dev_req(dev_req), .dev_we(dev_we),
        .dev_addr(dev_addr), .dev_wrdata(dev_wrdata), .dev_gnt(o_dev_gnt[1]),
        .dev_rddata(o_dev_rddata[1]), .dev_rdvalid(o_dev_rdvalid[1]),
        .mem_addr(o_mem_addr[1]), .mem_we(o_mem_we[1]), .mem_re(o_mem_re[1]),
        .mem_wrdata(o_mem_wrdata[1]), .mem_rddata(mem_rddata), .starve(o_starve[1]),
        .clr_starve(clr_starve), .mcu_err(o_mcu_err[1]));

    mcu_bus_arbiter #(.AW(16), .DW(16), .RD_LAT(3), .STARVE_LIM(64)) u3 (
        .clk(clk), .nsclr(nsclr), .mcu_addr(mcu_addr), .mcu_write(mcu_write),
        .mcu_read(mcu_read), .mcu_wrdata(mcu_wrdata), .mcu_rddata(o_mcu_rddata[2]),
        .mcu_rdvalid(o_mcu_rdvalid[2]), .dev_req(dev_req), .dev_we(dev_we),
        .dev_addr(dev_addr), .dev_wrdata(dev_wrdata), .dev_gnt(o_dev_gnt[2]),
        .dev_rddata(o_dev_rddata[2]), .dev_rdvalid(o_dev_rdvalid[2]),
        .mem_addr(o_mem_addr[2]), .mem_we(o_mem_we[2]), .mem_re(o_mem_re[2]),
        .mem_wrdata(o_mem_wrdata[2]), .mem_rddata(mem_rddata), .starve(o_starve[2]),
        .clr_starve(clr_starve), .mcu_err(o_mcu_err[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; inputs change here, outputs are
    // sampled #1 later, well away from the rising edge.
    task automatic cyc;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        nsclr = 1'b0; mcu_addr = '0; mcu_wrdata = '0; mcu_write = 1'b1; mcu_read = 1'b0;
        dev_req = 1'b1; dev_we = 1'b0; dev_addr = '0; dev_wrdata = '0;
        mem_rddata = '0; clr_starve = 1'b0;

        // Reset: grant/strobes forced low while nsclr=0, state cleared.
        #1;
        chk("rst_gnt", o_dev_gnt[0], 0);
        chk("rst_we", o_mem_we[0], 0);
        chk("rst_re", o_mem_re[0], 0);
        cyc; #1;
        chk("rst_starve", o_starve[0], 0);
        chk("rst_err", o_mcu_err[0], 0);
        chk("rst_dev_rddata", o_dev_rddata[0], 16'h0);
        chk("rst_mem_addr", o_mem_addr[0], 16'h0);
        nsclr = 1'b1; mcu_write = 1'b0; dev_req = 1'b0;

        // MCU write blocks a simultaneous device write.
        cyc;
        mcu_write = 1'b1; mcu_addr = 16'h0010; mcu_wrdata = 16'hA5A5;
        dev_req = 1'b1; dev_we = 1'b1; dev_addr = 16'h0030; dev_wrdata = 16'h5555;
        #1;
        chk("mcuw_we", o_mem_we[0], 1);
        chk("mcuw_re", o_mem_re[0], 0);
        chk("mcuw_addr", o_mem_addr[0], 16'h0010);
        chk("mcuw_data", o_mem_wrdata[0], 16'hA5A5);
        chk("mcuw_gnt", o_dev_gnt[0], 0);
        cyc;
        mcu_write = 1'b0;
        #1;
        chk("devw_gnt", o_dev_gnt[0], 1);
        chk("devw_we", o_mem_we[0], 1);
        chk("devw_addr", o_mem_addr[0], 16'h0030);
        chk("devw_data", o_mem_wrdata[0], 16'h5555);
        cyc;
        dev_req = 1'b0;
        #1;
        chk("idle_we", o_mem_we[0], 0);
        chk("idle_addr_hold", o_mem_addr[0], 16'h0030);
        chk("idle_data_hold", o_mem_wrdata[0], 16'h5555);

        // Device read, RD_LAT=1.
        cyc;
        dev_req = 1'b1; dev_we = 1'b0; dev_addr = 16'h0020;
        #1;
        chk("devr_gnt", o_dev_gnt[0], 1);
        chk("devr_re", o_mem_re[0], 1);
        chk("devr_addr", o_mem_addr[0], 16'h0020);
        cyc;
        dev_req = 1'b0; mem_rddata = 16'h1234;
        #1;
        chk("devr_valid", o_dev_rdvalid[0], 1);
        chk("devr_data", o_dev_rddata[0], 16'h1234);
        chk("devr_mcu_valid", o_mcu_rdvalid[0], 0);
        cyc;
        mem_rddata = 16'hFFFF;
        #1;
        chk("devr_pulse", o_dev_rdvalid[0], 0);
        chk("devr_hold", o_dev_rddata[0], 16'h1234);

        // Alternating reads with RD_LAT=3 (instance index 2).
        cyc; nsclr = 1'b0;
        cyc; nsclr = 1'b1;
        cyc;
        mcu_read = 1'b1; mcu_addr = 16'h0100; mem_rddata = 16'h0;
        #1;
        chk("alt_c0_re", o_mem_re[2], 1);
        cyc;
        mcu_read = 1'b0; dev_req = 1'b1; dev_we = 1'b0; dev_addr = 16'h0101;
        #1;
        chk("alt_c1_gnt", o_dev_gnt[2], 1);
        cyc;
        dev_req = 1'b0; mcu_read = 1'b1; mcu_addr = 16'h0102;
        #1;
        chk("alt_c2_novalid", o_mcu_rdvalid[2], 0);
        cyc;
        mcu_read = 1'b0; dev_req = 1'b1; dev_addr = 16'h0103; mem_rddata = 16'hA000;
        #1;
        chk("alt_r0_mvalid", o_mcu_rdvalid[2], 1);
        chk("alt_r0_mdata", o_mcu_rddata[2], 16'hA000);
        chk("alt_r0_dvalid", o_dev_rdvalid[2], 0);
        cyc;
        dev_req = 1'b0; mem_rddata = 16'hA001;
        #1;
        chk("alt_r1_dvalid", o_dev_rdvalid[2], 1);
        chk("alt_r1_ddata", o_dev_rddata[2], 16'hA001);
        chk("alt_r1_mvalid", o_mcu_rdvalid[2], 0);
        cyc;
        mem_rddata = 16'hA002;
        #1;
        chk("alt_r2_mvalid", o_mcu_rdvalid[2], 1);
        chk("alt_r2_mdata", o_mcu_rddata[2], 16'hA002);
        cyc;
        mem_rddata = 16'hA003;
        #1;
        chk("alt_r3_dvalid", o_dev_rdvalid[2], 1);
        chk("alt_r3_ddata", o_dev_rddata[2], 16'hA003);
        chk("alt_r3_mvalid", o_mcu_rdvalid[2], 0);
        cyc;
        mem_rddata = 16'h0;
        #1;
        chk("alt_end_mvalid", o_mcu_rdvalid[2], 0);
        chk("alt_end_dvalid", o_dev_rdvalid[2], 0);
        chk("alt_end_mhold", o_mcu_rddata[2], 16'hA002);
        chk("alt_end_dhold", o_dev_rddata[2], 16'hA003);

        // Starvation: device blocked by 64 consecutive MCU writes.
        cyc;
        mcu_write = 1'b1; mcu_addr = 16'h0040; mcu_wrdata = 16'h0001;
        dev_req = 1'b1; dev_we = 1'b0; dev_addr = 16'h0050;
        repeat (63) cyc;
        #1;
        chk("starve_at_63", o_starve[0], 0);
        cyc;
        #1;
        chk("starve_at_64", o_starve[0], 1);
        mcu_write = 1'b0;
        #1;
        chk("starve_gnt", o_dev_gnt[0], 1);
        cyc;
        dev_req = 1'b0; clr_starve = 1'b1;
        #1;
        chk("starve_sticky", o_starve[0], 1);
        cyc;
        clr_starve = 1'b0;
        #1;
        chk("starve_cleared", o_starve[0], 0);

        // Simultaneous MCU read and write: write wins, error flagged.
        cyc;
        mcu_write = 1'b1; mcu_read = 1'b1; mcu_addr = 16'h0060; mcu_wrdata = 16'hBEEF;
        mem_rddata = 16'h4444;
        #1;
        chk("rw_we", o_mem_we[0], 1);
        chk("rw_re", o_mem_re[0], 0);
        chk("rw_data", o_mem_wrdata[0], 16'hBEEF);
        cyc;
        mcu_write = 1'b0; mcu_read = 1'b0;
        #1;
        chk("rw_err", o_mcu_err[0], 1);
        chk("rw_no_rdvalid", o_mcu_rdvalid[0], 0);
        clr_starve = 1'b1;
        cyc;
        clr_starve = 1'b0;
        #1;
        chk("rw_err_cleared", o_mcu_err[0], 0);

        // Reset with two reads in flight, RD_LAT=2 (instance index 1).
        cyc;
        mcu_read = 1'b1; mcu_addr = 16'h0070; mem_rddata = 16'h7777;
        cyc;
        mcu_read = 1'b0; dev_req = 1'b1; dev_we = 1'b0; dev_addr = 16'h0071;
        cyc;
        dev_req = 1'b0; nsclr = 1'b0;
        cyc;
        nsclr = 1'b1;
        #1;
        chk("fl_mvalid_0", o_mcu_rdvalid[1], 0);
        chk("fl_dvalid_0", o_dev_rdvalid[1], 0);
        chk("fl_mdata", o_mcu_rddata[1], 16'h0);
        chk("fl_ddata", o_dev_rddata[1], 16'h0);
        cyc;
        #1;
        chk("fl_mvalid_1", o_mcu_rdvalid[1], 0);
        chk("fl_dvalid_1", o_dev_rdvalid[1], 0);
        chk("fl_starve", o_starve[1], 0);
        chk("fl_err", o_mcu_err[1], 0);
        cyc;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
